// File: rtl/poly_osc_pkg.sv
// Shared constants for the polyphonic oscillator: waveform selectors and
// the noise LFSR seed, tap mask and step function.
package poly_osc_pkg;

    localparam logic [2:0] WAVE_SAW   = 3'd0;
    localparam logic [2:0] WAVE_TRI   = 3'd1;
    localparam logic [2:0] WAVE_PULSE = 3'd2;
    localparam logic [2:0] WAVE_PWM   = 3'd3;
    localparam logic [2:0] WAVE_NOISE = 3'd4;

    // Galois form of x^16 + x^14 + x^13 + x^11, shifting towards bit 0.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/osc_wave_gen.sv
// Combinational waveform shaper: turns one voice's truncated phase, wave
// select, pwm threshold and the shared noise register into one sample.
module osc_wave_gen
    import poly_osc_pkg::*;
#(
    parameter int PHASE_W = 14,
    parameter int OUT_W   = 12
) (
    input  logic [PHASE_W-1:0] i_phase,
    input  logic [2:0]         i_wave,
    input  logic [OUT_W-1:0]   i_mod,
    input  logic [15:0]        i_lfsr,
    output logic [OUT_W-1:0]   o_sample
);

    localparam logic [OUT_W-1:0] SILENT = {1'b1, {(OUT_W-1){1'b0}}};

    logic [OUT_W-1:0]   w_top;
    logic [PHASE_W-2:0] w_t;
    logic [PHASE_W-2:0] w_tri_full;
    logic [OUT_W-1:0]   w_tri;
    logic [OUT_W-1:0]   w_noise;

    assign w_top      = i_phase[PHASE_W-1 -: OUT_W];
    assign w_t        = i_phase[PHASE_W-2:0];
    // Fold the second half of the cycle back down to form the triangle.
    assign w_tri_full = i_phase[PHASE_W-1] ? ~w_t : w_t;
    assign w_tri      = OUT_W'(w_tri_full >> (PHASE_W - 1 - OUT_W));
    assign w_noise    = OUT_W'(i_lfsr >> (16 - OUT_W));

    // NOTE: the default assignment ahead of the case keeps this block purely
    // combinational for every select value, so no latch can be inferred.
    always_comb begin
        o_sample = SILENT;
        case (i_wave)
            WAVE_SAW:   o_sample = w_top;
            WAVE_TRI:   o_sample = w_tri;
            WAVE_PULSE: o_sample = i_phase[PHASE_W-1] ? '0 : '1;
            WAVE_PWM:   o_sample = (w_top < i_mod) ? '1 : '0;
            WAVE_NOISE: o_sample = w_noise;
            default:    o_sample = SILENT;
        endcase
    end

endmodule

// File: rtl/poly_osc.sv
// Time-multiplexed polyphonic oscillator: each ce starts a pass that steps
// every voice once through a shared shaper and sums the samples.
module poly_osc
    import poly_osc_pkg::*;
#(
    parameter int VOICES  = 4,
    parameter int ACC_W   = 23,
    parameter int PHASE_W = 14,
    parameter int OUT_W   = 12,
    parameter int TUNE_W  = 16,
    localparam int VW     = $clog2(VOICES),
    localparam int MIX_W  = OUT_W + VW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              cfg_we,
    input  logic [VW-1:0]     cfg_voice,
    input  logic [TUNE_W-1:0] cfg_tune,
    input  logic [2:0]        cfg_wave,
    input  logic [OUT_W-1:0]  cfg_mod,
    input  logic              cfg_en,
    input  logic              cfg_sync,
    output logic [MIX_W-1:0]  mix_out,
    output logic              mix_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [OUT_W-1:0] SILENT = {1'b1, {(OUT_W-1){1'b0}}};

    logic [0:0]        r_state;
    logic [VW-1:0]     r_idx;
    logic [15:0]       r_lfsr;
    logic [MIX_W-1:0]  r_sum;
    logic [MIX_W-1:0]  r_mix_out;
    logic              r_mix_valid;

    logic [ACC_W-1:0]  r_acc  [VOICES];
    logic [TUNE_W-1:0] r_tune [VOICES];
    logic [2:0]        r_wave [VOICES];
    logic [OUT_W-1:0]  r_mod  [VOICES];
    logic              r_en   [VOICES];

    logic              w_run;
    logic              w_last;
    logic              w_sync_hit;
    logic [ACC_W-1:0]  w_acc_cur;
    logic [ACC_W-1:0]  w_acc_inc;
    logic [ACC_W-1:0]  w_acc_next;
    logic [PHASE_W-1:0] w_phase;
    logic [OUT_W-1:0]  w_shaped;
    logic [OUT_W-1:0]  w_sample;
    logic [MIX_W-1:0]  w_sum_next;

    assign w_run      = (r_state == ST_RUN);
    assign w_last     = (r_idx == VW'(VOICES - 1));
    assign w_sync_hit = cfg_we && cfg_sync && (cfg_voice == r_idx);

    // A sync landing on the stepping voice wins over its increment, and the
    // sample of that step is then taken from phase zero.
    assign w_acc_cur  = r_acc[r_idx];
    assign w_acc_inc  = w_acc_cur + ACC_W'(r_tune[r_idx]);
    assign w_acc_next = w_sync_hit ? '0 : (r_en[r_idx] ? w_acc_inc : w_acc_cur);
    assign w_phase    = w_acc_next[ACC_W-1 -: PHASE_W];

    osc_wave_gen #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W)
    ) u_wave_gen (
        .i_phase  (w_phase),
        .i_wave   (r_wave[r_idx]),
        .i_mod    (r_mod[r_idx]),
        .i_lfsr   (r_lfsr),
        .o_sample (w_shaped)
    );

    assign w_sample   = r_en[r_idx] ? w_shaped : SILENT;
    assign w_sum_next = r_sum + MIX_W'(w_sample);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_lfsr      <= LFSR_SEED;
            r_sum       <= '0;
            r_mix_out   <= '0;
            r_mix_valid <= 1'b0;
        end else begin
            r_mix_valid <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (ce) begin
                    r_state <= ST_RUN;
                    r_idx   <= '0;
                    r_sum   <= '0;
                end
            end else begin
                r_lfsr <= lfsr_next(r_lfsr);
                r_sum  <= w_sum_next;
                r_idx  <= r_idx + 1'b1;
                if (w_last) begin
                    r_state     <= ST_IDLE;
                    r_mix_out   <= w_sum_next;
                    r_mix_valid <= 1'b1;
                end
            end
        end
    end

    // NOTE: the per-voice arrays are reset explicitly because the voices
    // must come up disabled with zeroed accumulators, not merely defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < VOICES; v++) begin
                r_acc[v]  <= '0;
                r_tune[v] <= '0;
                r_wave[v] <= '0;
                r_mod[v]  <= '0;
                r_en[v]   <= 1'b0;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (cfg_we && cfg_sync && (cfg_voice == VW'(v))) begin
                    r_acc[v] <= '0;
                end else if (w_run && (r_idx == VW'(v))) begin
                    r_acc[v] <= w_acc_next;
                end
            end
            if (cfg_we) begin
                r_tune[cfg_voice] <= cfg_tune;
                r_wave[cfg_voice] <= cfg_wave;
                r_mod[cfg_voice]  <= cfg_mod;
                r_en[cfg_voice]   <= cfg_en;
            end
        end
    end

    assign mix_out   = r_mix_out;
    assign mix_valid = r_mix_valid;
    assign busy      = w_run;
    assign overrun   = ce && w_run;

endmodule

// File: tb/tb_poly_osc.sv
// Self-checking bench for poly_osc: directed scenarios plus randomized
// configurations, compared against an arithmetic model of the voices.
module tb_poly_osc;

    localparam int VOICES  = 4;
    localparam int ACC_MOD = 1 << 23;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        cfg_we;
    logic [1:0]  cfg_voice;
    logic [15:0] cfg_tune;
    logic [2:0]  cfg_wave;
    logic [11:0] cfg_mod;
    logic        cfg_en;
    logic        cfg_sync;
    logic [13:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int unsigned m_acc  [VOICES];
    int          m_tune [VOICES];
    int          m_wave [VOICES];
    int          m_mod  [VOICES];
    bit          m_en   [VOICES];
    int unsigned m_lfsr;

    poly_osc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .cfg_we    (cfg_we),
        .cfg_voice (cfg_voice),
        .cfg_tune  (cfg_tune),
        .cfg_wave  (cfg_wave),
        .cfg_mod   (cfg_mod),
        .cfg_en    (cfg_en),
        .cfg_sync  (cfg_sync),
        .mix_out   (mix_out),
        .mix_valid (mix_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- model ----------------
    function automatic int unsigned lfsr_step(input int unsigned s);
        // Galois register for x^16+x^14+x^13+x^11: output bit feeds taps.
        if (s % 2 == 1) return (s / 2) ^ 32'hB400;
        return s / 2;
    endfunction

    function automatic int model_sample(input int v, input int unsigned acc);
        int phase;
        int top;
        phase = int'(acc / 512);
        top   = phase / 4;
        case (m_wave[v])
            0: return top;
            1: return (phase < 8192) ? phase / 2 : (16383 - phase) / 2;
            2: return (phase < 8192) ? 4095 : 0;
            3: return (top < m_mod[v]) ? 4095 : 0;
            4: return int'(m_lfsr / 16);
            default: return 2048;
        endcase
    endfunction

    function automatic int model_pass(input int sync_v);
        int sum;
        sum = 0;
        for (int v = 0; v < VOICES; v++) begin
            if (v == sync_v) m_acc[v] = 0;
            else if (m_en[v]) m_acc[v] = (m_acc[v] + m_tune[v]) % ACC_MOD;
            sum += m_en[v] ? model_sample(v, m_acc[v]) : 2048;
            m_lfsr = lfsr_step(m_lfsr);
        end
        return sum;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VOICES; v++) begin
            m_acc[v] = 0; m_tune[v] = 0; m_wave[v] = 0; m_mod[v] = 0; m_en[v] = 0;
        end
        m_lfsr = 32'hACE1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ce = 1'b0; cfg_we = 1'b0; cfg_sync = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic cfg_write(input int v, input int tune, input int wave,
                             input int md, input bit en, input bit sync);
        tick();
        cfg_we = 1'b1; cfg_voice = 2'(v); cfg_tune = 16'(tune);
        cfg_wave = 3'(wave); cfg_mod = 12'(md); cfg_en = en; cfg_sync = sync;
        tick();
        cfg_we = 1'b0; cfg_sync = 1'b0;
        m_tune[v] = tune; m_wave[v] = wave; m_mod[v] = md; m_en[v] = en;
        if (sync) m_acc[v] = 0;
    endtask

    // One pass: ce in cycle t, checks busy window and result at t+5.
    task automatic run_pass(input string tag, output int got);
        int exp;
        exp = model_pass(-1);
        tick(); ce = 1'b1;
        tick(); ce = 1'b0; #1;
        for (int k = 1; k <= VOICES; k++) begin
            n_checks++;
            if ({busy, mix_valid, overrun} !== 3'b100) begin
                n_errors++;
                $display("FAIL %s step%0d busy/valid/overrun got=%b want=100", tag, k,
                         {busy, mix_valid, overrun});
            end
            tick(); #1;
        end
        n_checks++;
        if (mix_valid !== 1'b1 || busy !== 1'b0 || mix_out !== 14'(exp)) begin
            n_errors++;
            $display("FAIL %s result valid=%b busy=%b mix_out=%0d want valid=1 busy=0 mix_out=%0d",
                     tag, mix_valid, busy, mix_out, exp);
        end
        got = int'(mix_out);
        tick(); #1;
        n_checks++;
        if (mix_valid !== 1'b0 || mix_out !== 14'(exp)) begin
            n_errors++;
            $display("FAIL %s hold valid=%b mix_out=%0d want valid=0 mix_out=%0d",
                     tag, mix_valid, mix_out, exp);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b0; cfg_we = 1'b0; cfg_sync = 1'b0;
        cfg_voice = '0; cfg_tune = '0; cfg_wave = '0; cfg_mod = '0; cfg_en = 1'b0;
        #12;
        n_checks++;
        if ({mix_out, mix_valid, busy, overrun} !== 17'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got mix_out=%0d valid=%b busy=%b overrun=%b want all 0",
                     mix_out, mix_valid, busy, overrun);
        end
        tick();
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({mix_valid, busy} !== 2'b00) begin
                n_errors++;
                $display("FAIL reset_idle cycle%0d valid=%b busy=%b want 0 0", i, mix_valid, busy);
            end
        end
    endtask

    task automatic test_silence();
        int got;
        do_reset();
        run_pass("silence", got);
        n_checks++;
        if (got != 8192) begin
            n_errors++;
            $display("FAIL silence_sum got=%0d want=8192", got);
        end
    endtask

    task automatic test_saw();
        int got;
        int want[3] = '{6145, 6146, 6147};
        do_reset();
        cfg_write(0, 16'h0800, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_pass("saw", got);
            n_checks++;
            if (got != want[i]) begin
                n_errors++;
                $display("FAIL saw_pass%0d got=%0d want=%0d", i, got, want[i]);
            end
        end
    endtask

    task automatic test_pulse_wrap();
        int got;
        int prev;
        int toggles;
        do_reset();
        cfg_write(1, 16'hFFFF, 2, 0, 1'b1, 1'b0);
        prev = 4095;
        toggles = 0;
        for (int i = 0; i < 129; i++) begin
            run_pass("pulse", got);
            if ((got - 6144) != prev) toggles++;
            prev = got - 6144;
        end
        // Pass 65 crosses acc MSB, pass 129 wraps past 2^23.
        n_checks++;
        if (toggles != 2 || prev != 4095) begin
            n_errors++;
            $display("FAIL pulse_toggles got=%0d last=%0d want toggles=2 last=4095", toggles, prev);
        end
    endtask

    task automatic test_overrun();
        int exp;
        int n_ovr;
        int n_valid;
        do_reset();
        cfg_write(3, 16'h4321, 1, 0, 1'b1, 1'b0);
        exp = model_pass(-1);
        n_ovr = 0; n_valid = 0;
        tick(); ce = 1'b1;                 // cycle t
        tick(); ce = 1'b0;                 // t+1
        tick(); ce = 1'b1; #1;             // t+2
        n_checks++;
        if (overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun_pulse got=%b want=1", overrun);
        end
        n_ovr += int'(overrun);
        for (int c = 3; c <= 7; c++) begin
            tick(); ce = 1'b0; #1;
            n_ovr   += int'(overrun);
            n_valid += int'(mix_valid);
            if (c == 5) begin
                n_checks++;
                if (mix_valid !== 1'b1 || mix_out !== 14'(exp)) begin
                    n_errors++;
                    $display("FAIL overrun_result valid=%b mix_out=%0d want valid=1 mix_out=%0d",
                             mix_valid, mix_out, exp);
                end
            end
        end
        n_checks++;
        if (n_ovr != 1 || n_valid != 1) begin
            n_errors++;
            $display("FAIL overrun_counts overrun=%0d valid=%0d want 1 1", n_ovr, n_valid);
        end
    endtask

    task automatic test_sync();
        int got;
        int exp;
        do_reset();
        cfg_write(2, 16'h1234, 0, 0, 1'b1, 1'b0);
        run_pass("sync_pre", got);
        run_pass("sync_pre", got);
        exp = model_pass(2);
        tick(); ce = 1'b1;                 // t
        tick(); ce = 1'b0;                 // t+1 voice0
        tick();                            // t+2 voice1
        tick();                            // t+3 voice2
        cfg_we = 1'b1; cfg_voice = 2'd2; cfg_tune = 16'h1234; cfg_wave = 3'd0;
        cfg_mod = '0; cfg_en = 1'b1; cfg_sync = 1'b1;
        tick(); cfg_we = 1'b0; cfg_sync = 1'b0;   // t+4
        tick(); #1;                        // t+5
        n_checks++;
        if (mix_valid !== 1'b1 || mix_out !== 14'(exp) || exp != 6144) begin
            n_errors++;
            $display("FAIL sync_pass valid=%b mix_out=%0d want valid=1 mix_out=6144 (model %0d)",
                     mix_valid, mix_out, exp);
        end
        run_pass("sync_post", got);
        n_checks++;
        if (got != 6144 + (16'h1234 >> 11)) begin
            n_errors++;
            $display("FAIL sync_post got=%0d want=%0d", got, 6144 + (16'h1234 >> 11));
        end
    endtask

    task automatic test_random();
        int got;
        do_reset();
        for (int p = 0; p < 40; p++) begin
            int nw;
            nw = int'($urandom_range(0, 2));
            for (int w = 0; w < nw; w++) begin
                cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)),
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
            end
            run_pass("random", got);
        end
    endtask

    task automatic test_reset_midpass();
        int got;
        int n_valid;
        do_reset();
        cfg_write(0, 16'h0800, 0, 0, 1'b1, 1'b0);
        tick(); ce = 1'b1;                 // t
        tick(); ce = 1'b0;                 // t+1
        tick(); rst_n = 1'b0; #1;          // t+2
        n_checks++;
        if ({mix_out, mix_valid, busy, overrun} !== 17'd0) begin
            n_errors++;
            $display("FAIL midreset_outputs mix_out=%0d valid=%b busy=%b overrun=%b want all 0",
                     mix_out, mix_valid, busy, overrun);
        end
        tick();
        rst_n = 1'b1;
        model_reset();
        n_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_valid += int'(mix_valid) + int'(busy);
        end
        n_checks++;
        if (n_valid != 0) begin
            n_errors++;
            $display("FAIL midreset_quiet activity=%0d want=0", n_valid);
        end
        run_pass("midreset_after", got);
        n_checks++;
        if (got != 8192) begin
            n_errors++;
            $display("FAIL midreset_after got=%0d want=8192", got);
        end
    endtask

    initial begin
        test_reset();
        test_silence();
        test_saw();
        test_pulse_wrap();
        test_overrun();
        test_sync();
        test_random();
        test_reset_midpass();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
